// File: rtl/riscv_ahb3lite_sram_slave.sv
// AHB3-Lite word-organised SRAM slave: byte/half/word transfers, two-cycle ERROR on illegal access.
// Latency: WAIT_STATES+1 data-phase cycles per OKAY transfer, back-to-back accepts in the DATA cycle.
// Backpressure: HREADYOUT low in WAIT and ERR1; address phases are sampled only while HREADY is high.
module riscv_ahb3lite_sram_slave #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
  input  logic [XLEN-1:0]           HWDATA,
  output logic [XLEN-1:0]           HRDATA,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic [1:0]                HTRANS,
  input  logic                      HMASTLOCK,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q;
  logic [OFFW-1:0]     off_q;
  logic [2:0]          size_q;
  logic                write_q;
  logic [NB-1:0]       lane_en;
  logic [XLEN-1:0]     mem [MEM_DEPTH];

  logic [PHYS_ADDR_SIZE-1:0] word_addr;
  logic [PHYS_ADDR_SIZE-1:0] align_mask;
  logic                      legal;
  logic                      slave_rdy;
  logic                      accept;
  logic                      unused_ok;

  assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

  assign word_addr  = HADDR >> OFFW;
  assign align_mask = (PHYS_ADDR_SIZE'(1) << HSIZE) - PHYS_ADDR_SIZE'(1);
  assign legal      = (word_addr < PHYS_ADDR_SIZE'(MEM_DEPTH)) &&
                      (HSIZE <= 3'(OFFW)) &&
                      ((HADDR & align_mask) == '0);

  // Only states that show HREADYOUT=1 can end a data phase and take a new address.
  assign slave_rdy = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept    = slave_rdy && HSEL && HREADY && HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DATA: state_d = S_IDLE;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP   = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (!legal) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES - 1);
      end else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= HADDR[OFFW +: IDXW];
      off_q   <= HADDR[OFFW-1:0];
      size_q  <= HSIZE;
      write_q <= HWRITE;
    end
  end

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NB; i++) begin
      lane_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
    end
  end

  // Writes land at the end of DATA, so a read accepted in that cycle sees the merged word.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_riscv_ahb3lite_sram_slave.sv
// Bench for riscv_ahb3lite_sram_slave: two instances (0 and 3 wait states) driven by a pipelined
// AHB master; a per-cycle expected-response stream and byte-level memory image predict the bus.
module tb_riscv_ahb3lite_sram_slave;

  localparam int DEPTH = 1024;

  typedef struct {
    bit          rdy;
    bit          resp;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
  } exp_t;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0]       hsel;
  logic [1:0][31:0] haddr;
  logic [1:0][31:0] hwdata;
  logic [1:0][31:0] hrdata;
  logic [1:0]       hwrite;
  logic [1:0][2:0]  hsize;
  logic [1:0][2:0]  hburst;
  logic [1:0][3:0]  hprot;
  logic [1:0][1:0]  htrans;
  logic [1:0]       hmastlock;
  logic [1:0]       hready;
  logic [1:0]       hreadyout;
  logic [1:0]       hresp;
  logic [1:0]       force_nrdy;

  exp_t        ring   [2][16];
  int          head   [2];
  int          tail   [2];
  logic [31:0] mmem   [2][DEPTH];
  logic [3:0]  mknown [2][DEPTH];
  int          n_cmp, n_fail, cyc;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready[g] = hreadyout[g] & ~force_nrdy[g];
    riscv_ahb3lite_sram_slave #(
      .XLEN(32), .PHYS_ADDR_SIZE(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(g == 0 ? 0 : 3)
    ) u_dut (
      .HCLK(clk), .HRESET(rst[g]), .HSEL(hsel[g]), .HADDR(haddr[g]), .HWDATA(hwdata[g]),
      .HRDATA(hrdata[g]), .HWRITE(hwrite[g]), .HSIZE(hsize[g]), .HBURST(hburst[g]),
      .HPROT(hprot[g]), .HTRANS(htrans[g]), .HMASTLOCK(hmastlock[g]), .HREADY(hready[g]),
      .HREADYOUT(hreadyout[g]), .HRESP(hresp[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input bit rdy, input bit resp, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [2:0] sz);
    ring[d][tail[d]] = '{rdy, resp, rd, wr, a, sz};
    tail[d] = (tail[d] + 1) % 16;
  endtask

  // Expected data-phase cycles for one accepted transfer.
  task automatic schedule(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz);
    bit legal;
    int ws;
    ws    = (d == 0) ? 0 : 3;
    legal = ((a / 4) < DEPTH) && (sz <= 2) && ((a % (32'd1 << sz)) == 0);
    if (!legal) begin
      push(d, 1'b0, 1'b1, 1'b0, 1'b0, a, sz);
      push(d, 1'b1, 1'b1, 1'b0, 1'b0, a, sz);
    end else begin
      for (int i = 0; i < ws; i++) push(d, 1'b0, 1'b0, 1'b0, 1'b0, a, sz);
      push(d, 1'b1, 1'b0, !wr, wr, a, sz);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [31:0] er, m;
    int          w, lane;
    for (int d = 0; d < 2; d++) begin
      e = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0};
      if (rst[d]) head[d] = tail[d];
      else if (head[d] != tail[d]) begin
        e = ring[d][head[d]];
        head[d] = (head[d] + 1) % 16;
      end
      er = '0;
      m  = '1;
      if (e.rd) begin
        w  = int'(e.addr / 4);
        er = mmem[d][w];
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mknown[d][w][b]}};
      end
      check($sformatf("bus%0d_cycle%0d", d, cyc),
            {30'd0, hreadyout[d], hresp[d], hrdata[d] & m}, {30'd0, e.rdy, e.resp, er & m});
      if (e.wr) begin
        w = int'(e.addr / 4);
        for (int b = 0; b < (1 << e.size); b++) begin
          lane = int'(e.addr % 4) + b;
          mmem[d][w][8*lane +: 8] = hwdata[d][8*lane +: 8];
          mknown[d][w][lane] = 1'b1;
        end
      end
      if (!rst[d] && hsel[d] && hready[d] && htrans[d][1]) schedule(d, hwrite[d], haddr[d], hsize[d]);
    end
  end

  task automatic wait_ready(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = hready[d];
      @(posedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: actual=HREADY low required=HREADY high within 64 cycles", d);
    end
    #1;
  endtask

  // Drives one address phase, returns just after it is accepted with HWDATA set for its data phase.
  task automatic addr_phase(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd);
    hsel[d]      = 1'b1;
    haddr[d]     = a;
    hwrite[d]    = wr;
    hsize[d]     = sz;
    htrans[d]    = 2'b10;
    hburst[d]    = 3'($urandom);
    hprot[d]     = 4'($urandom);
    hmastlock[d] = 1'($urandom);
    wait_ready(d);
    htrans[d] = 2'b00;
    hsel[d]   = 1'($urandom);
    hwdata[d] = wd;
  endtask

  task automatic data_result(input int d, input string name, input logic [31:0] exp, input int exp_low);
    int low;
    bit got;
    low = 0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (hreadyout[d]) got = 1'b1;
      else low++;
    end
    check({name, "_done"}, 64'(got), 64'd1);
    check({name, "_data"}, 64'(hrdata[d]), 64'(exp));
    check({name, "_resp"}, 64'(hresp[d]), 64'd0);
    check({name, "_waits"}, 64'(low), 64'(exp_low));
    @(posedge clk);
    #1;
  endtask

  task automatic err_result(input int d, input string name);
    @(negedge clk);
    check({name, "_err1"}, {62'd0, hreadyout[d], hresp[d]}, 64'b01);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_err2"}, {62'd0, hreadyout[d], hresp[d]}, 64'b11);
    @(posedge clk);
    #1;
  endtask

  task automatic directed0();
    addr_phase(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    addr_phase(0, 1'b0, 32'h10, 3'd2, 32'h0);
    data_result(0, "t1_b2b_read", 32'hDEADBEEF, 0);
    addr_phase(0, 1'b1, 32'h10, 3'd2, 32'h11223344);
    addr_phase(0, 1'b1, 32'h13, 3'd0, 32'hAA000000);
    addr_phase(0, 1'b0, 32'h10, 3'd2, 32'h0);
    data_result(0, "t2_byte", 32'hAA223344, 0);
    addr_phase(0, 1'b1, 32'h12, 3'd1, 32'h55660000);
    addr_phase(0, 1'b0, 32'h10, 3'd2, 32'h0);
    data_result(0, "t2_half", 32'h55663344, 0);
    check("model_pin_word4", 64'(mmem[0][4]), 64'h55663344);
    addr_phase(0, 1'b0, 32'h1000, 3'd2, 32'h0);
    err_result(0, "t4_out_of_range");
    addr_phase(0, 1'b1, 32'h11, 3'd1, 32'h77770000);
    err_result(0, "t4_misaligned");
    addr_phase(0, 1'b0, 32'h10, 3'd2, 32'h0);
    data_result(0, "t4_unchanged", 32'h55663344, 0);
    hsel[0]   = 1'b1;
    haddr[0]  = 32'h10;
    hwrite[0] = 1'b1;
    hsize[0]  = 3'd2;
    hwdata[0] = 32'h0;
    htrans[0] = 2'b01;
    @(posedge clk); #1;
    htrans[0] = 2'b00;
    @(posedge clk); #1;
    force_nrdy[0] = 1'b1;
    htrans[0]     = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    htrans[0]     = 2'b00;
    force_nrdy[0] = 1'b0;
    @(negedge clk);
    check("t5_idle_ready", {62'd0, hreadyout[0], hresp[0]}, 64'b10);
    @(posedge clk); #1;
    addr_phase(0, 1'b0, 32'h10, 3'd2, 32'h0);
    data_result(0, "t5_unchanged", 32'h55663344, 0);
  endtask

  task automatic directed1();
    int t0;
    addr_phase(1, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
    addr_phase(1, 1'b0, 32'h40, 3'd2, 32'h0);
    data_result(1, "t3_single", 32'hCAFEF00D, 3);
    addr_phase(1, 1'b0, 32'h40, 3'd2, 32'h0);
    t0 = cyc;
    for (int i = 0; i < 3; i++) addr_phase(1, 1'b0, 32'h40, 3'd2, 32'h0);
    wait_ready(1);
    check("t3_four_reads_cycles", 64'(cyc - t0), 64'd16);
    addr_phase(1, 1'b1, 32'h20, 3'd2, 32'h11111111);
    wait_ready(1);
    addr_phase(1, 1'b1, 32'h20, 3'd2, 32'h99999999);
    #1 rst[1] = 1'b1;
    #1 check("t6_reset_outputs", {30'd0, hreadyout[1], hresp[1], hrdata[1]}, {30'd0, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    rst[1] = 1'b0;
    addr_phase(1, 1'b0, 32'h20, 3'd2, 32'h0);
    data_result(1, "t6_not_committed", 32'h11111111, 3);
  endtask

  task automatic rand_phase(input int d, input int n);
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int w = 0; w < 16; w++) addr_phase(d, 1'b1, 32'(w * 4), 3'd2, $urandom);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      if (r < 2) begin
        hsel[d]   = 1'($urandom);
        htrans[d] = 2'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        htrans[d] = 2'b00;
      end else begin
        sz = (r == 2) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 15)) * 4;
        if (r == 3) a = a + 32'($urandom_range(1, 3));
        else        a = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
        if (r == 4) a = a | 32'h1000;
        if (r == 5) a = a | 32'h8000_0000;
        addr_phase(d, 1'($urandom), a, sz, $urandom);
      end
    end
    wait_ready(d);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = '0; hsel = '0; haddr = '0; hwdata = '0; hwrite = '0; hsize = '0;
    hburst = '0; hprot = '0; htrans = '0; hmastlock = '0; force_nrdy = '0;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      head[d] = 0;
      tail[d] = 0;
      for (int w = 0; w < DEPTH; w++) begin
        mmem[d][w]   = '0;
        mknown[d][w] = '0;
      end
    end
    #1 rst = '1;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("reset_state%0d", d), {30'd0, hreadyout[d], hresp[d], hrdata[d]},
            {30'd0, 1'b1, 1'b0, 32'd0});
    repeat (2) @(posedge clk);
    #1 rst = '0;
    directed0();
    directed1();
    rand_phase(0, 300);
    rand_phase(1, 150);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
